// File: rtl/rv_mem_responder.sv
// rv_mem_responder: single-outstanding valid/ready word memory with byte-masked stores and fixed latency
module rv_mem_responder #(
    parameter int          ADDR_W    = 10,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_n;
    logic [3:0] cnt;
    logic we_q, err_q;
    logic [31:0] wdata_q;
    logic [3:0] be_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0] mem [2**ADDR_W];
    logic [32:0] off;
    logic bad, accept, commit;
    // 33-bit offset so a borrow flags addresses below the base
    always_comb begin
        off = {1'b0, req_addr} - {1'b0, BASE_ADDR};
        bad = |req_addr[1:0] || off[32] || |(off[31:0] >> (ADDR_W + 2));
    end
    assign req_ready = state == IDLE && !rst;
    assign accept    = req_valid && req_ready;
    assign commit    = state == WAIT && cnt == 4'd0;
    assign rsp_valid = state == RESP;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (req_valid ? WAIT : IDLE)
                : state == WAIT ? (cnt == 4'd0 ? RESP : WAIT)
                : (rsp_ready ? IDLE : RESP);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= 32'h0;
            be_q      <= 4'h0;
            idx_q     <= '0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                cnt     <= 4'(LATENCY - 1);
                we_q    <= req_we;
                err_q   <= bad;
                wdata_q <= req_wdata;
                be_q    <= req_be;
                idx_q   <= off[ADDR_W+1:2];
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                rsp_err   <= err_q;
                rsp_rdata <= (we_q || err_q) ? 32'h0 : mem[idx_q];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && commit && we_q && !err_q)
            for (int i = 0; i < 4; i++)
                if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
    end
endmodule

// File: tb/tb_rv_mem_responder.sv
// tb_rv_mem_responder: directed plus randomized checks of two responders (latency 1 and 4) against a word-map model
module tb_rv_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic        rv[2], rdy[2], vld[2], err[2];
    logic [31:0] rdata[2];
    logic        we = 1'b0, rsp_ready = 1'b0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [3:0]  be = 4'h0;
    int n_vec = 0, n_err = 0;
    logic [31:0] mdl[int];

    rv_mem_responder #(.ADDR_W(10), .LATENCY(1), .BASE_ADDR(32'h0)) u1 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .req_be(be), .rsp_valid(vld[0]),
        .rsp_ready(rsp_ready), .rsp_rdata(rdata[0]), .rsp_err(err[0]));
    rv_mem_responder #(.ADDR_W(10), .LATENCY(4), .BASE_ADDR(32'h0)) u4 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .req_be(be), .rsp_valid(vld[1]),
        .rsp_ready(rsp_ready), .rsp_rdata(rdata[1]), .rsp_err(err[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on responder s, with 'stall' cycles of response backpressure
    task automatic txn(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input int stall);
        int k, key;
        logic e_err;
        logic [31:0] held, nw;
        e_err = a[1:0] != 2'b00 || a >= 32'h1000;
        key = s * 1024 + int'(a[11:2]);
        if (w && !e_err && mdl.exists(key)) begin
            nw = mdl[key];
            for (int i = 0; i < 4; i++) if (b[i]) nw[8*i +: 8] = d[8*i +: 8];
            mdl[key] = nw;
        end else if (w && !e_err && b == 4'hF) begin
            mdl[key] = d;
        end
        k = 0;
        while (!rdy[s] && k < 20) begin tick(); k++; end
        chk("req_ready_idle", rdy[s], 1);
        rv[s] = 1'b1; we = w; addr = a; wdata = d; be = b;
        tick();
        rv[s] = 1'b0; we = $urandom; addr = $urandom; wdata = $urandom; be = 4'($urandom);
        k = 0;
        while (!vld[s] && k < 20) begin tick(); k++; end
        chk("latency", k, s ? 4 : 1);
        chk("rsp_err", err[s], e_err);
        if (!w && !e_err) begin
            if (mdl.exists(key)) chk("load_data", rdata[s], mdl[key]);
        end else chk("rdata_zero", rdata[s], 0);
        held = rdata[s];
        repeat (stall) begin
            tick();
            chk("hold_valid", vld[s], 1);
            chk("hold_data", rdata[s], held);
            chk("busy_ready", rdy[s], 0);
        end
        rsp_ready = 1'b1;
        chk("hs_ready", rdy[s], 0);
        tick();
        rsp_ready = 1'b0;
        chk("rsp_drop", vld[s], 0);
    endtask

    initial begin
        int s, r;
        logic [31:0] a;
        rv[0] = 1'b1; rv[1] = 1'b1;
        repeat (3) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                chk("rst_ready", rdy[i], 0);
                chk("rst_valid", vld[i], 0);
                chk("rst_rdata", rdata[i], 0);
                chk("rst_err", err[i], 0);
            end
        end
        rst = 1'b0; rv[0] = 1'b0; rv[1] = 1'b0;
        #1;
        chk("ready_after_rst0", rdy[0], 1);
        chk("ready_after_rst1", rdy[1], 1);
        txn(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        txn(0, 0, 32'h10, 32'h0, 4'h0, 0);
        txn(0, 1, 32'h20, 32'h11223344, 4'hF, 0);
        txn(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
        txn(0, 0, 32'h20, 32'h0, 4'h0, 1);
        chk("bytemask_model", mdl[32'h20 >> 2], 32'h11BB33DD);
        txn(0, 1, 32'h24, 32'h55667788, 4'h0, 0);
        txn(0, 0, 32'h13, 32'h0, 4'h0, 0);
        txn(0, 0, 32'h1000, 32'h0, 4'h0, 0);
        txn(0, 1, 32'hFFC, 32'h01020304, 4'hF, 0);
        txn(0, 1, 32'hFFE, 32'hFFFFFFFF, 4'hF, 0);
        txn(0, 0, 32'hFFC, 32'h0, 4'h0, 0);
        txn(1, 1, 32'h80, 32'hCAFE1234, 4'hF, 0);
        txn(1, 0, 32'h80, 32'h0, 4'h0, 5);
        txn(0, 1, 32'h40, 32'h12345678, 4'hF, 0);
        txn(0, 0, 32'h40, 32'h0, 4'h0, 0);
        rv[0] = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'hBAD0BAD0; be = 4'hF;
        tick();
        rv[0] = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_rdata", rdata[0], 0);
        repeat (3) begin
            chk("midrst_valid", vld[0], 0);
            tick();
        end
        txn(0, 0, 32'h40, 32'h0, 4'h0, 0);
        chk("midrst_model", mdl[32'h40 >> 2], 32'h12345678);
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 8; i++) txn(p, 1, 32'h400 + 32'(4 * i), $urandom, 4'hF, 0);
        for (int t = 0; t < 60; t++) begin
            s = int'($urandom_range(1));
            r = int'($urandom_range(7));
            a = r == 0 ? 32'h400 + 32'(4 * $urandom_range(31)) + 32'($urandom_range(3, 1))
              : r == 1 ? 32'h1000 + 32'(4 * $urandom_range(255))
              : 32'h400 + 32'(4 * $urandom_range(7));
            txn(s, 1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(2)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
